// File: rtl/sram_bus_pkg.sv
// rtl/sram_bus_pkg.sv - shared types and constants for the SRAM bus sequencer
package sram_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LATCH,
        ST_RD_OE,
        ST_RD_WAIT,
        ST_RD_CAP,
        ST_WR_DATA,
        ST_WR_STB,
        ST_DONE
    } sram_state_t;

    localparam logic [7:0] BUS_DRIVE   = 8'hFF;
    localparam logic [7:0] BUS_RELEASE = 8'h00;
    localparam int         RD_WAIT_MAX = 3;

    // Terminal value of the 2-bit wait counter for a given number of wait cycles
    function automatic logic [1:0] wait_last(input int rd_wait);
        return (rd_wait > 0) ? 2'(rd_wait - 1) : 2'd0;
    endfunction

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// rtl/sram_bus_arbiter_if.sv - requester-side handshake bundle for both ports
interface sram_bus_arbiter_if;
    logic       req0;
    logic       req1;
    logic       we0;
    logic       we1;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic       ack0;
    logic       ack1;
    logic [7:0] rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata
    );
endinterface

// File: rtl/sram_bus_arbiter_rr_arbiter2.sv
// rtl/sram_bus_arbiter_rr_arbiter2.sv - two-port grant logic with last-grant memory
module rr_arbiter2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       grant_en_i,
    output logic       grant_o
);

    logic last_q;
    logic last_d;

    // Grant decision: lone requester wins, ties go by priority mode
    always_comb begin
        grant_o = 1'b0;
        if (req_i == 2'b10) begin
            grant_o = 1'b1;
        end else if (req_i == 2'b11) begin
            grant_o = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
        end
    end

    assign last_d = (grant_en_i && (req_i != 2'b00)) ? grant_o : last_q;

    // Last-grant memory; starts at port 1 so port 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - two-port sequencer for the multiplexed external SRAM bus
module sram_bus_arbiter
    import sram_bus_pkg::*;
#(
    parameter int RD_WAIT    = 0,
    parameter int FIXED_PRIO = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_bus_arbiter_if.slave  req_if,
    output logic               latch_le,
    output logic               mem_oe_n,
    output logic               mem_we_n,
    output logic [7:0]         bus_out,
    input  logic [7:0]         bus_in,
    output logic [7:0]         bus_oe
);

    localparam int         RD_WAIT_EFF = (RD_WAIT > RD_WAIT_MAX) ? RD_WAIT_MAX : RD_WAIT;
    localparam logic [1:0] WAIT_LAST   = wait_last(RD_WAIT_EFF);

    sram_state_t state_q;
    logic        gnt_q;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic [1:0]  wait_cnt_q;
    logic        latch_le_q;
    logic        mem_oe_n_q;
    logic        mem_we_n_q;
    logic [7:0]  bus_out_q;
    logic [7:0]  bus_oe_q;
    logic        ack0_q;
    logic        ack1_q;
    logic [7:0]  rdata_q;

    logic [1:0]  req_vec;
    logic        grant_en;
    logic        grant;
    logic        sel_we;
    logic [7:0]  sel_addr;
    logic [7:0]  sel_wdata;

    assign req_vec   = {req_if.req1, req_if.req0};
    assign grant_en  = (state_q == ST_IDLE) && (req_vec != 2'b00);
    assign sel_we    = grant ? req_if.we1    : req_if.we0;
    assign sel_addr  = grant ? req_if.addr1  : req_if.addr0;
    assign sel_wdata = grant ? req_if.wdata1 : req_if.wdata0;

    rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_vec),
        .grant_en_i (grant_en),
        .grant_o    (grant)
    );

    // Bus sequencer: outputs are set on the transition into the state that shows them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= 8'h00;
            wait_cnt_q <= 2'd0;
            latch_le_q <= 1'b0;
            mem_oe_n_q <= 1'b1;
            mem_we_n_q <= 1'b1;
            bus_out_q  <= 8'h00;
            bus_oe_q   <= BUS_RELEASE;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata_q    <= 8'h00;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_en) begin
                        gnt_q      <= grant;
                        we_q       <= sel_we;
                        wdata_q    <= sel_wdata;
                        latch_le_q <= 1'b1;
                        bus_oe_q   <= BUS_DRIVE;
                        bus_out_q  <= sel_addr;
                        state_q    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // Address keeps driving through LATCH for hold across the latch fall
                    latch_le_q <= 1'b0;
                    state_q    <= ST_LATCH;
                end
                ST_LATCH: begin
                    if (we_q) begin
                        bus_out_q <= wdata_q;
                        state_q   <= ST_WR_DATA;
                    end else begin
                        // Release the pads in the same cycle the SRAM is enabled
                        bus_oe_q   <= BUS_RELEASE;
                        mem_oe_n_q <= 1'b0;
                        state_q    <= ST_RD_OE;
                    end
                end
                ST_RD_OE: begin
                    wait_cnt_q <= 2'd0;
                    state_q    <= (RD_WAIT_EFF == 0) ? ST_RD_CAP : ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q <= ST_RD_CAP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                    end
                end
                ST_RD_CAP: begin
                    rdata_q    <= bus_in;
                    mem_oe_n_q <= 1'b1;
                    ack0_q     <= ~gnt_q;
                    ack1_q     <= gnt_q;
                    state_q    <= ST_DONE;
                end
                ST_WR_DATA: begin
                    mem_we_n_q <= 1'b0;
                    state_q    <= ST_WR_STB;
                end
                ST_WR_STB: begin
                    // Data stays driven into DONE for write hold
                    mem_we_n_q <= 1'b1;
                    ack0_q     <= ~gnt_q;
                    ack1_q     <= gnt_q;
                    state_q    <= ST_DONE;
                end
                ST_DONE: begin
                    bus_oe_q <= BUS_RELEASE;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    latch_le_q <= 1'b0;
                    mem_oe_n_q <= 1'b1;
                    mem_we_n_q <= 1'b1;
                    bus_oe_q   <= BUS_RELEASE;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign latch_le     = latch_le_q;
    assign mem_oe_n     = mem_oe_n_q;
    assign mem_we_n     = mem_we_n_q;
    assign bus_out      = bus_out_q;
    assign bus_oe       = bus_oe_q;
    assign req_if.ack0  = ack0_q;
    assign req_if.ack1  = ack1_q;
    assign req_if.rdata = rdata_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - randomized self-checking bench with SRAM and transaction model
module tb_sram_bus_arbiter;
    import sram_bus_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: round-robin, no read wait. Instance 1: fixed priority, two wait cycles.
    logic [1:0][1:0]      req_v;
    logic [1:0][1:0]      we_v;
    logic [1:0][1:0][7:0] addr_v;
    logic [1:0][1:0][7:0] wdata_v;
    logic [1:0][1:0]      ack_v;
    logic [1:0][7:0]      rdata_v;
    logic [1:0]           le_v;
    logic [1:0]           oe_n_v;
    logic [1:0]           we_n_v;
    logic [1:0][7:0]      bout_v;
    logic [1:0][7:0]      boe_v;
    logic [1:0][7:0]      bin_v;

    logic [1:0][7:0] lat_v;
    logic [7:0]      mem [2][256];
    logic [7:0]      model_mem [2][256];
    int              last_g [2];
    bit              filled = 1'b0;
    bit              mon_en = 1'b0;
    int              n_cmp  = 0;
    int              n_bad  = 0;

    function automatic logic [7:0] init_val(input int g, input logic [7:0] a);
        logic [7:0] gv;
        gv = 8'(g);
        return (a == 8'h42) ? 8'hA5 : ((a ^ 8'h5A) + gv);
    endfunction

    function automatic int rdw(input int g);
        return (g == 1) ? 2 : 0;
    endfunction

    function automatic bit fixed_prio(input int g);
        return (g == 1);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_bus_arbiter_if rif ();
        assign rif.req0   = req_v[g][0];
        assign rif.req1   = req_v[g][1];
        assign rif.we0    = we_v[g][0];
        assign rif.we1    = we_v[g][1];
        assign rif.addr0  = addr_v[g][0];
        assign rif.addr1  = addr_v[g][1];
        assign rif.wdata0 = wdata_v[g][0];
        assign rif.wdata1 = wdata_v[g][1];
        assign ack_v[g]   = {rif.ack1, rif.ack0};
        assign rdata_v[g] = rif.rdata;
        assign bin_v[g]   = oe_n_v[g] ? 8'hEE : mem[g][lat_v[g]];

        sram_bus_arbiter #(
            .RD_WAIT    ((g == 1) ? 2 : 0),
            .FIXED_PRIO ((g == 1) ? 1 : 0)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_if   (rif),
            .latch_le (le_v[g]),
            .mem_oe_n (oe_n_v[g]),
            .mem_we_n (we_n_v[g]),
            .bus_out  (bout_v[g]),
            .bus_in   (bin_v[g]),
            .bus_oe   (boe_v[g])
        );
    end

    // External address latch and SRAM array
    always @(posedge clk) begin
        if (!filled) begin
            for (int g = 0; g < 2; g++)
                for (int a = 0; a < 256; a++)
                    mem[g][a] <= init_val(g, 8'(a));
            filled <= 1'b1;
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (le_v[g]) lat_v[g] <= bout_v[g];
                if (!we_n_v[g] && boe_v[g] == BUS_DRIVE) mem[g][lat_v[g]] <= bout_v[g];
            end
        end
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus-contention invariants checked every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            for (int g = 0; g < 2; g++) begin
                expect_eq("inv_drive_vs_oe", 32'(boe_v[g] == BUS_DRIVE && !oe_n_v[g]), 32'd0);
                expect_eq("inv_oe_we", 32'(!oe_n_v[g] && !we_n_v[g]), 32'd0);
                expect_eq("inv_le_strobe", 32'(le_v[g] && (!oe_n_v[g] || !we_n_v[g])), 32'd0);
            end
        end
    end

    task automatic access(input int g, input int p, input logic we, input logic [7:0] a,
                          input logic [7:0] d);
        int n, le_hi, oe_lo, we_lo, other;
        logic done;
        n = 0; le_hi = 0; oe_lo = 0; we_lo = 0; other = 0; done = 1'b0;
        req_v[g][p] = 1'b1; we_v[g][p] = we; addr_v[g][p] = a; wdata_v[g][p] = d;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (le_v[g]) begin
                le_hi++;
                expect_eq("addr_on_bus", 32'(bout_v[g]), 32'(a));
            end
            if (!oe_n_v[g]) oe_lo++;
            if (!we_n_v[g]) begin
                we_lo++;
                expect_eq("wdata_on_bus", 32'(bout_v[g]), 32'(d));
                expect_eq("wdata_driven", 32'(boe_v[g]), 32'(BUS_DRIVE));
            end
            if (ack_v[g][1-p]) other++;
            if (ack_v[g][p]) done = 1'b1;
        end
        req_v[g][p] = 1'b0;
        expect_eq("ack_seen", 32'(done), 32'd1);
        expect_eq("latency", n, we ? 5 : 5 + rdw(g));
        expect_eq("le_width", le_hi, 1);
        expect_eq("oe_width", oe_lo, we ? 0 : 2 + rdw(g));
        expect_eq("we_width", we_lo, we ? 1 : 0);
        expect_eq("other_ack", other, 0);
        last_g[g] = p;
        if (we) model_mem[g][a] = d;
        else    expect_eq("rdata", 32'(rdata_v[g]), 32'(model_mem[g][a]));
        @(negedge clk);
    endtask

    task automatic contend(input int g, input int nacks);
        int got, cyc, p, exp_p;
        logic [7:0] ca [2];
        logic [7:0] cd [2];
        logic       cw [2];
        got = 0; cyc = 0;
        for (int q = 0; q < 2; q++) begin
            cw[q] = 1'($urandom_range(0, 1));
            ca[q] = 8'($urandom_range(0, 15));
            cd[q] = 8'($urandom);
            we_v[g][q] = cw[q]; addr_v[g][q] = ca[q]; wdata_v[g][q] = cd[q];
            req_v[g][q] = 1'b1;
        end
        while (got < nacks && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ack_v[g] != 2'b00) begin
                expect_eq("ack_onehot", 32'(ack_v[g] == 2'b11), 32'd0);
                p = ack_v[g][1] ? 1 : 0;
                exp_p = fixed_prio(g) ? 0 : 1 - last_g[g];
                expect_eq("grant_order", p, exp_p);
                last_g[g] = exp_p;
                if (cw[p]) model_mem[g][ca[p]] = cd[p];
                else       expect_eq("rdata_contend", 32'(rdata_v[g]), 32'(model_mem[g][ca[p]]));
                got++;
                cw[p] = 1'($urandom_range(0, 1));
                ca[p] = 8'($urandom_range(0, 15));
                cd[p] = 8'($urandom);
                we_v[g][p] = cw[p]; addr_v[g][p] = ca[p]; wdata_v[g][p] = cd[p];
            end
        end
        expect_eq("contend_count", got, nacks);
        req_v[g] = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_n;
        req_v = '0; we_v = '0; addr_v = '0; wdata_v = '0;
        last_g[0] = 1; last_g[1] = 1;
        for (int g = 0; g < 2; g++)
            for (int a = 0; a < 256; a++)
                model_mem[g][a] = init_val(g, 8'(a));

        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            expect_eq("rst_le", 32'(le_v[g]), 32'd0);
            expect_eq("rst_oe_n", 32'(oe_n_v[g]), 32'd1);
            expect_eq("rst_we_n", 32'(we_n_v[g]), 32'd1);
            expect_eq("rst_bus_oe", 32'(boe_v[g]), 32'h00);
            expect_eq("rst_bus_out", 32'(bout_v[g]), 32'h00);
            expect_eq("rst_ack", 32'(ack_v[g]), 32'd0);
            expect_eq("rst_rdata", 32'(rdata_v[g]), 32'h00);
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Directed: single read, write then read-back, contention, read wait states
        access(0, 0, 1'b0, 8'h42, 8'h00);
        access(0, 1, 1'b1, 8'h10, 8'h3C);
        access(0, 1, 1'b0, 8'h10, 8'h00);
        contend(0, 4);
        contend(1, 4);
        access(1, 1, 1'b0, 8'hFF, 8'h00);
        access(1, 0, 1'b1, 8'h20, 8'h77);
        access(1, 1, 1'b0, 8'h20, 8'h00);

        // Reset during the write strobe aborts the access
        model_mem[0][8'h55] = mem[0][8'h55];
        req_v[0][0] = 1'b1; we_v[0][0] = 1'b1; addr_v[0][0] = 8'h55;
        wdata_v[0][0] = ~model_mem[0][8'h55];
        wait_n = 0;
        while (we_n_v[0] && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        expect_eq("wr_stb_reached", 32'(we_n_v[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        expect_eq("abort_we_n", 32'(we_n_v[0]), 32'd1);
        expect_eq("abort_bus_oe", 32'(boe_v[0]), 32'h00);
        expect_eq("abort_ack", 32'(ack_v[0]), 32'd0);
        req_v = '0;
        repeat (2) begin
            @(negedge clk);
            expect_eq("abort_ack_hold", 32'(ack_v[0]), 32'd0);
        end
        rst_n = 1'b1;
        last_g[0] = 1; last_g[1] = 1;
        repeat (3) begin
            @(negedge clk);
            expect_eq("post_rst_idle_le", 32'(le_v[0]), 32'd0);
            expect_eq("post_rst_idle_ack", 32'(ack_v[0]), 32'd0);
        end
        expect_eq("mem_unmodified", 32'(mem[0][8'h55]), 32'(model_mem[0][8'h55]));
        access(0, 0, 1'b0, 8'h55, 8'h00);
        contend(0, 2);

        // Random traffic against the transaction model
        for (int k = 0; k < 24; k++) begin
            int g, m;
            g = $urandom_range(0, 1);
            m = $urandom_range(0, 2);
            if (m < 2) access(g, m, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
            else       contend(g, $urandom_range(2, 4));
        end

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Sequencer and two-port arbiter for the shared external SRAM bus. The bus is an 8-bit multiplexed data/address path with an external address latch (`latch_le`), `mem_oe_n` and `mem_we_n`. The block serialises single-byte read and write requests from two requesters (port 0: SUBNEG core, port 1: program loader/debug) into latch → strobe → capture sequences. It also guarantees that the pad driver and the SRAM never drive the bus in the same cycle. It sits between the cores and the `uio`/`uo_out` pads.

## Interface
Parameters:
- `RD_WAIT`, default 0: extra cycles `mem_oe_n` is held low before read capture (0–3).
- `FIXED_PRIO`, default 0: 0 = round-robin; 1 = port 0 always wins ties.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req0`, `req1`  in  1  access request; level; held until matching `ack`.
- `we0`, `we1`  in  1  1 = write, 0 = read; stable while `req` is high.
- `addr0`, `addr1`  in  8  SRAM address.
- `wdata0`, `wdata1`  in  8  write data.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata`  out  8  last read byte; valid with `ack`, held until the next read capture.
- `latch_le`  out  1  address latch enable; transparent when high, captures on fall.
- `mem_oe_n`  out  1  SRAM output enable, active-low.
- `mem_we_n`  out  1  SRAM write enable, active-low.
- `bus_out`  out  8  pad output data.
- `bus_in`  in  8  pad input data.
- `bus_oe`  out  8  pad direction; 8'hFF = drive, 8'h00 = release.

## Operation
- Reset values: `latch_le`=0, `mem_oe_n`=1, `mem_we_n`=1, `bus_oe`=8'h00, `bus_out`=8'h00, `ack0`/`ack1`=0, `rdata`=8'h00, state IDLE, last-grant = port 1 (so port 0 wins the first tie).
- All outputs are registered.
- FSM states: IDLE, ADDR, LATCH, RD_OE, RD_WAIT, RD_CAP, WR_DATA, WR_STB, DONE.
- IDLE: `bus_oe`=00 and all strobes inactive.
  - If any `req` is high, grant one port, latch its `we`/`addr`/`wdata`, and go to ADDR.
- Arbitration:
  - Only one requester active: grant it.
  - Both active, `FIXED_PRIO`=0: grant the port that is not last-grant, then update last-grant.
  - Both active, `FIXED_PRIO`=1: grant port 0.
  - Grant is decided only in IDLE. A request arriving mid-cycle waits for IDLE.
- ADDR: `latch_le`=1, `bus_oe`=FF, `bus_out`=addr.
- LATCH: `latch_le`=0. Bus still drives addr, giving hold time across the latch fall.
- Read path:
  - RD_OE: `bus_oe`=00, `mem_oe_n`=0.
  - RD_WAIT: repeats `RD_WAIT` times and is skipped when `RD_WAIT`=0.
  - RD_CAP: `mem_oe_n`=0; `rdata` ← `bus_in` at the end of this state.
- Write path:
  - WR_DATA: `bus_out`=wdata, `bus_oe`=FF.
  - WR_STB: `mem_we_n`=0, data held.
- DONE:
  - Strobes inactive (`mem_oe_n`=1, `mem_we_n`=1). On writes, data is still driven for hold.
  - `ack` of the granted port = 1.
  - Next state is IDLE.
- Invariants:
  - Never `bus_oe`=FF while `mem_oe_n`=0.
  - Never `mem_oe_n`=0 and `mem_we_n`=0 together.
  - `latch_le` is never high while either strobe is active.
- Requester rule: deassert `req` on the edge that samples `ack`. The one-cycle IDLE gap prevents double issue. A requester wanting back-to-back accesses may keep `req` high with new `addr`/`we`/`wdata`.
- Reset mid-operation: abort immediately; all outputs go to reset values asynchronously; no `ack` is issued; the aborted access is lost.
- A `req` dropped before `ack`: protocol violation. The cycle completes anyway and `ack` is still pulsed.

## Timing
- Latency, `RD_WAIT`=0, bus idle: `req` sampled high in IDLE at edge t0 → `ack` high in cycle t0+5, for both read and write (ADDR, LATCH, RD_OE/WR_DATA, RD_CAP/WR_STB, DONE).
- Read latency is 5+`RD_WAIT`.
- Throughput: one access per 6+`RD_WAIT` cycles (includes IDLE).
- `latch_le` high for 1 cycle; `mem_we_n` low for 1 cycle; `mem_oe_n` low for 2+`RD_WAIT` cycles.
- Bus turnaround: at least 1 cycle with `bus_oe`=00 and `mem_oe_n`=1 between a read capture and the next address drive (DONE followed by IDLE).

## Structure
- Package `sram_bus_pkg`:
  - state enum `sram_state_t`;
  - `BUS_DRIVE`=8'hFF and `BUS_RELEASE`=8'h00;
  - `RD_WAIT_MAX`=3.
- Sub-module `rr_arbiter2`: 2-input grant plus last-grant register, updated on a `grant_en` strobe from IDLE. It honours `FIXED_PRIO`.
- The FSM, the wait counter (2 bits) and the output registers live in the top.

## Test plan
- Single read: mem[8'h42]=8'hA5, `req0`=1, `we0`=0, `addr0`=8'h42 → `latch_le` pulse with `bus_out`=8'h42, `mem_oe_n` low 2 cycles, `ack0` at t0+5, `rdata`=8'hA5.
- Single write: port 1, `addr1`=8'h10, `wdata1`=8'h3C → `mem_we_n` low exactly 1 cycle while `bus_out`=8'h3C and `bus_oe`=FF; a follow-up read of 8'h10 returns 8'h3C.
- Contention: `req0` and `req1` held high for 4 accesses, `FIXED_PRIO`=0 → ack order 0,1,0,1. With `FIXED_PRIO`=1 → 0,0,0,0 while port 1 is starved.
- `RD_WAIT`=2: read of 8'hFF → `mem_oe_n` low 4 cycles, `ack` at t0+7.
- Reset mid-cycle: assert `rst_n`=0 during WR_STB → `mem_we_n`=1 immediately, no `ack`, FSM in IDLE after release, memory unmodified.
- Continuous assertion check over random traffic: no `bus_oe`=FF with `mem_oe_n`=0, and no simultaneous `mem_oe_n`/`mem_we_n` low.
